// File: rtl/thermometer_burst_sequencer.sv
// thermometer_burst_sequencer
// Splits a lane-count command into beats of at most WIDTH lanes. Each beat
// carries the binary lane count and the matching thermometer lane mask.
// All beat outputs are decoded from the registered remaining count, so they
// never depend combinationally on beat_ready.
module thermometer_burst_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [LEN_W-1:0]               cmd_len,
    output logic                           beat_valid,
    input  logic                           beat_ready,
    output logic [$clog2(WIDTH+1)-1:0]     beat_cnt,
    output logic [WIDTH-1:0]               beat_mask,
    output logic                           beat_last,
    output logic                           busy,
    output logic                           done
);

    localparam int CW = $clog2(WIDTH + 1);
    // Compare/subtract width wide enough for both the length field and WIDTH,
    // so WIDTH is never truncated when LEN_W is narrow.
    localparam int AW = (LEN_W > CW) ? LEN_W : CW;
    localparam logic [AW-1:0] WIDTH_EXT = AW'(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               done_q, done_d;

    logic [AW-1:0]      rem_ext;
    logic [AW-1:0]      cnt_ext;
    logic               last_w;

    // Beat size is min(remaining, WIDTH); the beat is final when it drains
    // everything that is left, so the subtraction can never underflow.
    assign rem_ext = AW'(remaining_q);
    assign last_w  = (rem_ext <= WIDTH_EXT);
    assign cnt_ext = last_w ? rem_ext : WIDTH_EXT;

    // State, remaining-count and done-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    // Next-state and handshake outputs; everything is forced quiet during reset.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        cmd_ready   = 1'b0;
        beat_valid  = 1'b0;
        busy        = 1'b0;
        beat_last   = 1'b0;
        beat_cnt    = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        remaining_d = cmd_len;
                        state_d     = RUN;
                    end else begin
                        // Empty command completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                beat_valid = 1'b1;
                busy       = 1'b1;
                beat_last  = last_w;
                beat_cnt   = CW'(cnt_ext);
                if (beat_ready) begin
                    remaining_d = LEN_W'(rem_ext - cnt_ext);
                    if (last_w) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            cmd_ready  = 1'b0;
            beat_valid = 1'b0;
            busy       = 1'b0;
            beat_last  = 1'b0;
            beat_cnt   = '0;
        end
    end

    assign done = done_q & ~rst;

    // Thermometer mask: lane gi is enabled when the beat covers more than gi lanes.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign beat_mask[gi] = beat_valid && (cnt_ext > AW'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_thermometer_burst_sequencer.sv
// Self-checking bench for thermometer_burst_sequencer (WIDTH=4, LEN_W=8).
// Expected beats come from splitting each command length into chunks of
// at most WIDTH lanes.
module tb_thermometer_burst_sequencer;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             beat_valid;
    logic             beat_ready;
    logic [CW-1:0]    beat_cnt;
    logic [WIDTH-1:0] beat_mask;
    logic             beat_last;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    thermometer_burst_sequencer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_cnt   (beat_cnt),
        .beat_mask  (beat_mask),
        .beat_last  (beat_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_quiet(input string tag);
        chk({tag, "_cmd_ready"},  cmd_ready,  1);
        chk({tag, "_beat_valid"}, beat_valid, 0);
        chk({tag, "_busy"},       busy,       0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"},  cmd_ready,  0);
        chk({tag, "_beat_valid"}, beat_valid, 0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_beat_cnt"},   beat_cnt,   0);
        chk({tag, "_beat_mask"},  beat_mask,  0);
        chk({tag, "_beat_last"},  beat_last,  0);
    endtask

    // Offer one command in the current (ready) cycle and follow it to completion.
    // first_stall: cycles of backpressure on the first beat.
    // rand_stall : random 0..2 stall cycles on every beat instead.
    // hold_next  : >=0 keeps cmd_valid high with this length throughout RUN.
    task automatic run_cmd(input int len, input int first_stall, input bit rand_stall,
                           input int hold_next);
        int q[$];
        int rem;
        int c;
        int nb;
        int stall;
        rem = len;
        while (rem > 0) begin
            c = (rem > WIDTH) ? WIDTH : rem;
            q.push_back(c);
            rem -= c;
        end
        nb = q.size();

        chk("pre_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        cycle();
        if (hold_next >= 0) cmd_len = LEN_W'(hold_next);
        else                cmd_valid = 1'b0;

        if (nb == 0) begin
            chk("zero_done",       done,       1);
            chk("zero_beat_valid", beat_valid, 0);
            chk("zero_cmd_ready",  cmd_ready,  1);
            $display("cmd len=%0d beats=0", len);
            return;
        end

        for (int b = 0; b < nb; b++) begin
            stall = (b == 0) ? first_stall : 0;
            if (rand_stall) stall = $urandom_range(0, 2);
            for (int s = 0; s <= stall; s++) begin
                beat_ready = (s == stall);
                chk("beat_valid", beat_valid, 1);
                chk("busy",       busy,       1);
                chk("cmd_ready",  cmd_ready,  0);
                chk("done_run",   done,       0);
                chk("beat_cnt",   beat_cnt,   q[b]);
                chk("beat_mask",  beat_mask,  (1 << q[b]) - 1);
                chk("beat_last",  beat_last,  (b == nb - 1) ? 1 : 0);
                cycle();
            end
        end
        beat_ready = 1'b0;
        chk("end_done",       done,       1);
        chk("end_cmd_ready",  cmd_ready,  1);
        chk("end_beat_valid", beat_valid, 0);
        chk("end_busy",       busy,       0);
        $display("cmd len=%0d beats=%0d", len, nb);
    endtask

    initial begin
        int len;
        int gap;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_len    = '0;
        beat_ready = 1'b0;

        // Reset state
        cycle();
        cycle();
        chk_reset_outputs("rst");
        chk("rst_done", done, 0);
        rst = 1'b0;
        cycle();
        chk_idle_quiet("post_rst");
        chk("post_rst_done", done, 0);

        // Directed scenarios
        run_cmd(10, 0, 1'b0, -1);
        run_cmd(4, 0, 1'b0, -1);
        run_cmd(0, 0, 1'b0, -1);
        cycle();
        chk("zero_done_one_cycle", done, 0);
        run_cmd(7, 3, 1'b0, -1);
        run_cmd(255, 0, 1'b0, -1);
        // cmd_valid held during RUN: next command accepted in the done cycle
        run_cmd(6, 0, 1'b0, 9);
        run_cmd(9, 0, 1'b0, -1);
        cycle();

        // Reset mid-burst
        cmd_valid = 1'b1;
        cmd_len   = 8'd20;
        cycle();
        cmd_valid  = 1'b0;
        beat_ready = 1'b1;
        chk("mid_b1_cnt", beat_cnt, 4);
        cycle();
        chk("mid_b2_cnt", beat_cnt, 4);
        cycle();
        chk("mid_b3_valid", beat_valid, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        cycle();
        chk_reset_outputs("mid_rst_edge");
        chk("mid_rst_done", done, 0);
        rst        = 1'b0;
        beat_ready = 1'b0;
        cycle();
        chk_idle_quiet("mid_after");
        chk("mid_after_done", done, 0);
        $display("reset mid-burst len=20 after 2 beats");
        run_cmd(5, 0, 1'b0, -1);

        // Randomized commands with random stalls and idle gaps
        for (int i = 0; i < 25; i++) begin
            len = $urandom_range(0, 45);
            run_cmd(len, 0, 1'b1, -1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cycle();
                chk("gap_done", done, 0);
                chk_idle_quiet("gap");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
